// File: rtl/divrem_seq_pkg.sv
// Shared constants and types for the sequential divide/remainder unit.
package divrem_seq_pkg;

  // Default iteration count: one quotient bit per cycle for a 32-bit divide.
  localparam int unsigned DIV_ITERS_DEFAULT = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [31:0] DIV_BYZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUO    = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  // Magnitude of a possibly-signed operand; unsigned operands pass through.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/divrem_seq_step.sv
// One combinational restoring-division iteration.
module divrem_seq_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] dvd_in,
  input  logic [31:0] dvs,
  output logic [31:0] rem_out,
  output logic [31:0] dvd_out
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted = {rem_in, dvd_in[31]};
    ge      = (shifted >= {1'b0, dvs});
    // Low 32 bits of the difference are exact whenever ge holds.
    diff    = shifted[31:0] - dvs;
    rem_out = ge ? diff : shifted[31:0];
    // Quotient bits fill the dividend register from the bottom.
    dvd_out = {dvd_in[30:0], ge};
  end

endmodule

// File: rtl/divrem_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU.
module divrem_seq
  import divrem_seq_pkg::*;
#(
  parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic [31:0] dividend,
  input  logic [31:0] divider,
  input  logic        divsigned,
  input  logic        diven_p,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        diven,
  output logic        divout_valid
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      acc_q, dvd_q, dvs_q;
  logic             quo_neg_q, rem_neg_q;
  logic [31:0]      quo_q, rem_q;
  logic [31:0]      step_rem, step_dvd;
  logic             div_zero, sgn_ovf, last_iter;

  assign div_zero  = (divider == 32'd0);
  assign sgn_ovf   = divsigned && (dividend == 32'h8000_0000) && (divider == 32'hFFFF_FFFF);
  assign last_iter = (cnt_q == CNT_W'(DIV_ITERS - 1));

  divrem_seq_step u_step (
    .rem_in  (acc_q),
    .dvd_in  (dvd_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (cpurst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d      = state_q;
    diven        = 1'b0;
    divout_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (diven_p) state_d = (div_zero || sgn_ovf) ? StDone : StCalc;
      end
      StCalc: begin
        diven = 1'b1;
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        diven   = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        divout_valid = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (diven_p) begin
            if (div_zero) begin
              quo_q <= DIV_BYZERO_QUO;
              rem_q <= dividend;
            end else if (sgn_ovf) begin
              quo_q <= DIV_OVF_QUO;
              rem_q <= '0;
            end else begin
              dvd_q     <= mag32(dividend, divsigned);
              dvs_q     <= mag32(divider, divsigned);
              acc_q     <= '0;
              cnt_q     <= '0;
              quo_neg_q <= divsigned && (dividend[31] ^ divider[31]);
              rem_neg_q <= divsigned && dividend[31];
            end
          end
        end
        StCalc: begin
          acc_q <= step_rem;
          dvd_q <= step_dvd;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        StFix: begin
          quo_q <= quo_neg_q ? (~dvd_q + 32'd1) : dvd_q;
          rem_q <= rem_neg_q ? (~acc_q + 32'd1) : acc_q;
        end
        default: ;
      endcase
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: tb/tb_divrem_seq.sv
// Self-checking bench for divrem_seq: directed table, random ops vs. model, corner sequences.
module tb_divrem_seq;

  logic        clk = 1'b0;
  logic        cpurst;
  logic [31:0] dividend, divider;
  logic        divsigned, diven_p;
  logic [31:0] quo, rem;
  logic        diven, divout_valid;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  divrem_seq dut (
    .clk          (clk),
    .cpurst       (cpurst),
    .dividend     (dividend),
    .divider      (divider),
    .divsigned    (divsigned),
    .diven_p      (diven_p),
    .quo          (quo),
    .rem          (rem),
    .diven        (diven),
    .divout_valid (divout_valid)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: RISC-V DIV/REM semantics from plain arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    lat = 1;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
      lat = 34;
    end else begin
      q = a / b;
      r = a % b;
      lat = 34;
    end
  endtask

  // Issue one op from IDLE and check result, latency, busy span, pulse width and hold.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input int elat);
    int          lat, busy;
    logic [31:0] gq, gr;
    lat = -1;
    busy = 0;
    gq = 'x;
    gr = 'x;
    @(negedge clk);
    dividend = a;
    divider = b;
    divsigned = s;
    diven_p = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Operands after the accepting edge must not matter.
        diven_p = 1'b0;
        dividend = $urandom;
        divider = $urandom;
        divsigned = ~s;
      end
      if (diven) busy++;
      if (divout_valid) begin
        lat = c;
        gq = quo;
        gr = rem;
        break;
      end
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy"}, busy, (elat == 1) ? 0 : 33);
    chk({tag, "_quo"}, gq, eq);
    chk({tag, "_rem"}, gr, er);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, divout_valid}, 32'd0);
    chk({tag, "_hold"}, quo, eq);
  endtask

  task automatic wait_valid(input string tag, output logic [31:0] gq, output logic [31:0] gr);
    bit seen;
    seen = 1'b0;
    gq = 'x;
    gr = 'x;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (divout_valid) begin
        seen = 1'b1;
        gq = quo;
        gr = rem;
      end
    end
    chk({tag, "_seen"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, eq, er, gq, gr;
    logic        s;
    int          elat, seen, npulse, p0, p1;

    vecs[0] = '{32'd100,       32'd7,          1'b0, 32'd14,        32'd2,          34};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
    vecs[2] = '{32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,          34};
    vecs[3] = '{32'h1234_5678, 32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1};
    vecs[4] = '{32'h1234_5678, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,          1};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'd0,         32'h8000_0000, 34};
    vecs[7] = '{32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,          34};

    cpurst = 1'b1;
    diven_p = 1'b0;
    dividend = '0;
    divider = '0;
    divsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_quo", quo, 32'd0);
    chk("reset_rem", rem, 32'd0);
    chk("reset_busy", {31'b0, diven}, 32'd0);
    chk("reset_valid", {31'b0, divout_valid}, 32'd0);
    cpurst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                             vecs[i].q, vecs[i].r, vecs[i].lat);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_div(a, b, s, eq, er, elat);
      run_op($sformatf("rnd%0d", i), a, b, s, eq, er, elat);
    end

    // Reset wins over a simultaneous start; first edge after release accepts.
    @(negedge clk);
    cpurst = 1'b1;
    diven_p = 1'b1;
    dividend = 32'd100;
    divider = 32'd7;
    divsigned = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", {31'b0, diven}, 32'd0);
    chk("rst_prio_valid", {31'b0, divout_valid}, 32'd0);
    cpurst = 1'b0;
    @(negedge clk);
    chk("first_accept_busy", {31'b0, diven}, 32'd1);
    diven_p = 1'b0;
    wait_valid("first_accept", gq, gr);
    chk("first_accept_quo", gq, 32'd14);
    chk("first_accept_rem", gr, 32'd2);
    @(negedge clk);

    // Reset in T+10 discards the operation.
    @(negedge clk);
    dividend = 32'd100;
    divider = 32'd7;
    divsigned = 1'b0;
    diven_p = 1'b1;
    @(negedge clk);
    diven_p = 1'b0;
    chk("midop_busy", {31'b0, diven}, 32'd1);
    repeat (9) @(negedge clk);
    cpurst = 1'b1;
    @(negedge clk);
    cpurst = 1'b0;
    chk("midop_quo", quo, 32'd0);
    chk("midop_rem", rem, 32'd0);
    chk("midop_busy_clr", {31'b0, diven}, 32'd0);
    chk("midop_valid_clr", {31'b0, divout_valid}, 32'd0);
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (divout_valid) seen++;
    end
    chk("midop_no_valid", seen, 0);
    run_op("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

    // Start held for 80 cycles; operands scrambled only while busy.
    npulse = 0;
    p0 = -1;
    p1 = -1;
    @(negedge clk);
    dividend = 32'd100;
    divider = 32'd7;
    divsigned = 1'b0;
    diven_p = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      if (divout_valid) begin
        if (npulse == 0) p0 = k;
        else if (npulse == 1) p1 = k;
        npulse++;
        chk("held_quo", quo, 32'd14);
        chk("held_rem", rem, 32'd2);
      end
      if (diven) begin
        dividend = $urandom;
        divider = $urandom;
        divsigned = 1'($urandom_range(0, 1));
      end else begin
        dividend = 32'd100;
        divider = 32'd7;
        divsigned = 1'b0;
      end
    end
    diven_p = 1'b0;
    chk("held_pulses", npulse, 2);
    chk("held_first", p0, 34);
    chk("held_spacing", p1 - p0, 35);
    wait_valid("held_drain", gq, gr);
    chk("held_drain_quo", gq, 32'd14);
    chk("held_drain_rem", gr, 32'd2);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
